// File: rtl/als_light_averager.sv
// -----------------------------------------------------------------------------
// als_light_averager
//
// Purpose:
//   Samples the 8-bit light field of the PmodALS receiver word once every
//   SAMPLE_PERIOD clocks, averages 2^LOG2_N samples and publishes the
//   truncated mean with a one-cycle valid pulse. A hysteretic `dark` flag is
//   derived from each new average.
//
// Optional feature (macro ALS_MIN_MAX_EN):
//   Adds min_light / max_light outputs that track the extreme per-sample
//   light values since reset or clear.
//
// Ports:
//   clock         in   1  system clock, rising edge
//   reset_n       in   1  asynchronous active-low reset
//   value         in  16  raw receiver frame, light = value[11:4]
//   clear         in   1  synchronous restart of the averaging window
//   average       out  8  last completed average
//   average_valid out  1  one-cycle pulse, average just updated
//   dark          out  1  hysteretic darkness flag
//   min_light     out  8  (ALS_MIN_MAX_EN only) smallest sample seen
//   max_light     out  8  (ALS_MIN_MAX_EN only) largest sample seen
// -----------------------------------------------------------------------------
module als_light_averager #(
  parameter int unsigned SAMPLE_PERIOD = 10000,
  parameter int unsigned LOG2_N        = 4,
  parameter int unsigned DARK_ON       = 40,
  parameter int unsigned DARK_OFF      = 60
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        clear,
  output logic [7:0]  average,
  output logic        average_valid,
  output logic        dark
`ifdef ALS_MIN_MAX_EN
  ,
  output logic [7:0]  min_light,
  output logic [7:0]  max_light
`endif
);

  localparam int unsigned TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int unsigned AW = 8 + LOG2_N;
  localparam int unsigned N  = 1 << LOG2_N;

  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);
  localparam logic [8:0]    DARK_ON_W  = 9'(DARK_ON);
  localparam logic [8:0]    DARK_OFF_W = 9'(DARK_OFF);

  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    average_q, average_d;
  logic          valid_q, valid_d;
  logic          dark_q, dark_d;

  logic [7:0]    light_s;
  logic          sample_s;
  logic          last_s;
  logic [AW-1:0] sum_s;
  logic [7:0]    avg_new_s;
  logic          unused_bits_s;

  assign light_s       = value[11:4];
  assign unused_bits_s = ^{value[15:12], value[3:0]};
  assign sample_s      = (timer_q == TIMER_LAST);
  assign last_s        = (count_q == COUNT_LAST);
  // The accumulator is sized so that N full-scale samples still fit.
  assign sum_s         = acc_q + {{LOG2_N{1'b0}}, light_s};
  assign avg_new_s     = sum_s[LOG2_N +: 8];

  // Next-state logic for timer, window accumulation, average and dark flag.
  always_comb begin
    timer_d   = timer_q;
    count_d   = count_q;
    acc_d     = acc_q;
    average_d = average_q;
    valid_d   = 1'b0;
    dark_d    = dark_q;
    if (clear) begin
      // clear wins over a coincident sample; average and dark hold.
      timer_d = {TW{1'b0}};
      count_d = {CW{1'b0}};
      acc_d   = {AW{1'b0}};
    end else if (sample_s) begin
      timer_d = {TW{1'b0}};
      if (last_s) begin
        count_d   = {CW{1'b0}};
        acc_d     = {AW{1'b0}};
        average_d = avg_new_s;
        valid_d   = 1'b1;
        // Hysteresis: only crossing the far threshold flips the flag.
        case (dark_q)
          1'b0: begin
            if ({1'b0, avg_new_s} < DARK_ON_W) begin
              dark_d = 1'b1;
            end else begin
              dark_d = 1'b0;
            end
          end
          1'b1: begin
            if ({1'b0, avg_new_s} > DARK_OFF_W) begin
              dark_d = 1'b0;
            end else begin
              dark_d = 1'b1;
            end
          end
          default: dark_d = 1'b0;
        endcase
      end else begin
        count_d = count_q + CW'(1);
        acc_d   = sum_s;
      end
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= {TW{1'b0}};
      count_q   <= {CW{1'b0}};
      acc_q     <= {AW{1'b0}};
      average_q <= 8'h00;
      valid_q   <= 1'b0;
      dark_q    <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      average_q <= average_d;
      valid_q   <= valid_d;
      dark_q    <= dark_d;
    end
  end

  assign average       = average_q;
  assign average_valid = valid_q;
  assign dark          = dark_q;

`ifdef ALS_MIN_MAX_EN
  logic [7:0] min_q, min_d;
  logic [7:0] max_q, max_d;

  // Next-state logic for the per-sample extremes.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear) begin
      min_d = 8'hFF;
      max_d = 8'h00;
    end else if (sample_s) begin
      if (light_s < min_q) begin
        min_d = light_s;
      end else begin
        min_d = min_q;
      end
      if (light_s > max_q) begin
        max_d = light_s;
      end else begin
        max_d = max_q;
      end
    end else begin
      min_d = min_q;
      max_d = max_q;
    end
  end

  // Extreme-value registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= 8'hFF;
      max_q <= 8'h00;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_light = min_q;
  assign max_light = max_q;
`endif

endmodule

// File: tb/tb_als_light_averager.sv
// -----------------------------------------------------------------------------
// tb_als_light_averager
//
// Directed self-checking bench for als_light_averager with SAMPLE_PERIOD=4,
// LOG2_N=2 (one window = 16 clock edges), DARK_ON=40, DARK_OFF=60.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_als_light_averager;

  logic        clock;
  logic        reset_n;
  logic [15:0] value;
  logic        clear;
  logic [7:0]  average;
  logic        average_valid;
  logic        dark;
`ifdef ALS_MIN_MAX_EN
  logic [7:0]  min_light;
  logic [7:0]  max_light;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  als_light_averager #(
    .SAMPLE_PERIOD(4),
    .LOG2_N       (2),
    .DARK_ON      (40),
    .DARK_OFF     (60)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .value        (value),
    .clear        (clear),
    .average      (average),
    .average_valid(average_valid),
    .dark         (dark)
`ifdef ALS_MIN_MAX_EN
    ,
    .min_light    (min_light),
    .max_light    (max_light)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle away from the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present one light value per sample edge for a whole window.
  task automatic window(input logic [7:0] l0, input logic [7:0] l1,
                        input logic [7:0] l2, input logic [7:0] l3);
    logic [7:0] ls [4];
    ls[0] = l0; ls[1] = l1; ls[2] = l2; ls[3] = l3;
    for (int i = 0; i < 4; i++) begin
      value = {4'hA, ls[i], 4'h5};
      step(4);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    value   = 16'h0000;
    #12;
    check("rst_average", {8'h00, average}, 16'd0);
    check("rst_valid", {15'h0, average_valid}, 16'd0);
    check("rst_dark", {15'h0, dark}, 16'd0);
`ifdef ALS_MIN_MAX_EN
    check("rst_min", {8'h00, min_light}, 16'hFF);
    check("rst_max", {8'h00, max_light}, 16'h00);
`endif

    // Test 1: constant light 100, pulses after edges 16 and 32.
    step(1);
    value   = 16'h0640;
    reset_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step(1);
      check("t1_no_pulse", {15'h0, average_valid}, 16'd0);
    end
    step(1);
    check("t1_valid16", {15'h0, average_valid}, 16'd1);
    check("t1_avg16", {8'h00, average}, 16'd100);
    check("t1_dark16", {15'h0, dark}, 16'd0);
    step(1);
    check("t1_valid17", {15'h0, average_valid}, 16'd0);
    check("t1_avg17_hold", {8'h00, average}, 16'd100);
    step(14);
    check("t1_valid31", {15'h0, average_valid}, 16'd0);
    step(1);
    check("t1_valid32", {15'h0, average_valid}, 16'd1);

    // Test 2: 10+11+12+14 = 47, 47>>2 = 11, which sets dark.
    window(8'd10, 8'd11, 8'd12, 8'd14);
    check("t2_valid", {15'h0, average_valid}, 16'd1);
    check("t2_avg", {8'h00, average}, 16'd11);
    check("t2_dark", {15'h0, dark}, 16'd1);

    // Test 3: hysteresis.
    window(8'd50, 8'd50, 8'd50, 8'd50);
    check("t3_avg50", {8'h00, average}, 16'd50);
    check("t3_dark50", {15'h0, dark}, 16'd1);
    window(8'd60, 8'd60, 8'd60, 8'd60);
    check("t3_dark60", {15'h0, dark}, 16'd1);
    window(8'd61, 8'd61, 8'd61, 8'd61);
    check("t3_dark61", {15'h0, dark}, 16'd0);
    window(8'd45, 8'd45, 8'd45, 8'd45);
    check("t3_dark45", {15'h0, dark}, 16'd0);
    window(8'd39, 8'd39, 8'd39, 8'd39);
    check("t3_avg39", {8'h00, average}, 16'd39);
    check("t3_dark39", {15'h0, dark}, 16'd1);

    // Test 4: clear on the window-completing edge discards the window.
    value = 16'h0640;
    step(15);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t4_clear_valid", {15'h0, average_valid}, 16'd0);
    check("t4_clear_avg", {8'h00, average}, 16'd39);
    check("t4_clear_dark", {15'h0, dark}, 16'd1);
    step(15);
    check("t4_valid31", {15'h0, average_valid}, 16'd0);
    step(1);
    check("t4_valid32", {15'h0, average_valid}, 16'd1);
    check("t4_avg32", {8'h00, average}, 16'd100);
    check("t4_dark32", {15'h0, dark}, 16'd0);

    window(8'd20, 8'd20, 8'd20, 8'd20);
    check("t4b_dark20", {15'h0, dark}, 16'd1);

    // Test 5: asynchronous reset mid-window.
    value = 16'h0FF0;
    step(9);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_avg", {8'h00, average}, 16'd0);
    check("t5_async_valid", {15'h0, average_valid}, 16'd0);
    check("t5_async_dark", {15'h0, dark}, 16'd0);
    step(1);
    reset_n = 1'b1;
    step(15);
    check("t5_valid15", {15'h0, average_valid}, 16'd0);
    check("t5_avg15", {8'h00, average}, 16'd0);
    step(1);
    check("t5_valid16", {15'h0, average_valid}, 16'd1);
    check("t5_avg16", {8'h00, average}, 16'd255);

`ifdef ALS_MIN_MAX_EN
    // Test 6: min/max tracking and clear.
    check("t6_min_pre", {8'h00, min_light}, 16'd255);
    check("t6_max_pre", {8'h00, max_light}, 16'd255);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t6_min_clr", {8'h00, min_light}, 16'hFF);
    check("t6_max_clr", {8'h00, max_light}, 16'h00);
    window(8'd200, 8'd3, 8'd90, 8'd255);
    check("t6_min", {8'h00, min_light}, 16'd3);
    check("t6_max", {8'h00, max_light}, 16'd255);
    check("t6_avg", {8'h00, average}, 16'd137);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t6_min_clr2", {8'h00, min_light}, 16'hFF);
    check("t6_max_clr2", {8'h00, max_light}, 16'h00);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
